// File: rtl/xsimbus_master.sv
// xsimbus_master: XSimBus initiator; decodes a core load/store to one device and
// runs a SETUP / ACCESS / DONE bus cycle, returning ack, rdata and err to the core.
module xsimbus_master #(
   parameter int DATA_W      = 32,
   parameter int DEV_ADDR_W  = 8,
   parameter int NUM_DEV     = 4,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      core_req_in,
   input  logic                      core_we_in,
   input  logic [31:0]               core_addr_in,
   input  logic [DATA_W-1:0]         core_wdata_in,
   output logic                      core_ready_out,
   output logic                      core_ack_out,
   output logic [DATA_W-1:0]         core_rdata_out,
   output logic                      core_err_out,
   output logic [NUM_DEV-1:0]        bus_sel_out,
   output logic [DEV_ADDR_W-1:0]     bus_addr_out,
   output logic [DATA_W-1:0]         bus_data_out,
   output logic                      bus_rw_out,
   input  logic [NUM_DEV*DATA_W-1:0] bus_rdata_in
);
   localparam int IDX_W = $clog2(NUM_DEV);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [NUM_DEV-1:0]    sel_q, sel_d;
   logic [DEV_ADDR_W-1:0] baddr_q, baddr_d;
   logic [DATA_W-1:0]     bdata_q, bdata_d;
   logic                  rw_q, rw_d;
   logic [IDX_W-1:0]      idx_in;
   logic                  mapped;

   assign idx_in = core_addr_in[DEV_ADDR_W+IDX_W-1:DEV_ADDR_W];
   assign mapped = core_addr_in[31:DEV_ADDR_W+IDX_W] == '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      sel_d   = sel_q;
      baddr_d = baddr_q;
      bdata_d = bdata_q;
      rw_d    = rw_q;
      case (state_q)
         IDLE: if (core_req_in) begin
            we_d  = core_we_in;
            idx_d = idx_in;
            if (mapped) begin
               state_d = SETUP;
               sel_d   = NUM_DEV'(1) << idx_in;
               baddr_d = core_addr_in[DEV_ADDR_W-1:0];
               bdata_d = core_wdata_in;
               rw_d    = 1'b0;
            end else begin
               // unmapped: complete immediately without touching the bus
               state_d = DONE;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            rw_d    = we_q;
            cnt_d   = 4'(WAIT_CYCLES);
         end
         ACCESS: if (cnt_q == 4'd0) begin
            state_d = DONE;
            sel_d   = '0;
            rw_d    = 1'b0;
            ack_d   = 1'b1;
            err_d   = 1'b0;
            rdata_d = we_q ? rdata_q : bus_rdata_in[idx_q*DATA_W +: DATA_W];
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         sel_q   <= '0;
         baddr_q <= '0;
         bdata_q <= '0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         sel_q   <= sel_d;
         baddr_q <= baddr_d;
         bdata_q <= bdata_d;
         rw_q    <= rw_d;
      end
   end

   assign core_ready_out = state_q == IDLE;
   assign core_ack_out   = ack_q;
   assign core_rdata_out = rdata_q;
   assign core_err_out   = err_q;
   assign bus_sel_out    = sel_q;
   assign bus_addr_out   = baddr_q;
   assign bus_data_out   = bdata_q;
   assign bus_rw_out     = rw_q;
endmodule
